hazard_unit: RTL

Parametrised hazard, forwarding and flush controller for the Riscv151 in-order pipeline, generalised to STAGES pipeline slots past decode and configurable ALU/load result latencies. Sits beside the decoder in the I stage. It tracks in-flight destination registers in a scoreboard shift register, stalls decode on load-use hazards, and emits registered per-operand forward selects for the X stage. It also squashes the decode instruction on a redirect and exposes a saturating stall counter for performance monitoring.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_match.sv | 37 +++
 rtl/hazard_unit.sv | 89 ++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: forward encoding,
// default result latencies and scoreboard entry field widths.
package hazard_pkg;

  localparam int FWD_RF      = 0;
  localparam int DEF_ALU_LAT = 1;
  localparam int DEF_LD_LAT  = 2;
  localparam int SB_RD_W     = 5;
  localparam int SB_FLAG_W   = 3;

  // Earliest slot at which an entry's result can be forwarded.
  function automatic int slot_lat(input logic is_load, input int alu_lat, input int ld_lat);
    return is_load ? ld_lat : alu_lat;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-side bundle between the decoder (master) and the hazard unit (slave).
interface hazard_if #(
  parameter int RW    = 5,
  parameter int SW    = 2,
  parameter int CNT_W = 32
);
  logic             dec_valid;
  logic [RW-1:0]    dec_rs1;
  logic [RW-1:0]    dec_rs2;
  logic             dec_rs1_used;
  logic             dec_rs2_used;
  logic [RW-1:0]    dec_rd;
  logic             dec_we;
  logic             dec_is_load;
  logic             flush;
  logic             cnt_clr;
  logic             stall;
  logic             issue;
  logic [SW-1:0]    fwd_a_x;
  logic [SW-1:0]    fwd_b_x;
  logic             wb_we;
  logic [RW-1:0]    wb_rd;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_we, dec_is_load, flush, cnt_clr,
    input  stall, issue, fwd_a_x, fwd_b_x, wb_we, wb_rd, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_we, dec_is_load, flush, cnt_clr,
    output stall, issue, fwd_a_x, fwd_b_x, wb_we, wb_rd, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// Priority encoder over the scoreboard for one source operand: finds the
// youngest in-flight writer and flags it as a hazard if not yet forwardable.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int RW      = SB_RD_W,
  parameter int ALU_LAT = DEF_ALU_LAT,
  parameter int LD_LAT  = DEF_LD_LAT,
  parameter int SW      = $clog2(STAGES)
) (
  input  logic [STAGES-1:1]         i_vld,
  input  logic [STAGES-1:1]         i_we,
  input  logic [STAGES-1:1]         i_ld,
  input  logic [STAGES-1:1][RW-1:0] i_rd,
  input  logic [RW-1:0]             i_rs,
  input  logic                      i_used,
  output logic                      o_hit,
  output logic [SW-1:0]             o_k,
  output logic                      o_hazard
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_hit    = 1'b0;
    o_k      = SW'(FWD_RF);
    o_hazard = 1'b0;
    for (int k = STAGES-1; k >= 1; k--) begin
      if (i_used && (i_rs != '0) && i_vld[k] && i_we[k] && (i_rd[k] == i_rs)) begin
        o_hit    = 1'b1;
        o_k      = SW'(k);
        o_hazard = (k < slot_lat(i_ld[k], ALU_LAT, LD_LAT));
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, X-stage forward select and redirect squash for an in-order
// pipeline; in-flight writers are tracked in a per-slot shift scoreboard.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int RW      = SB_RD_W,
  parameter int ALU_LAT = DEF_ALU_LAT,
  parameter int LD_LAT  = DEF_LD_LAT,
  parameter int CNT_W   = 32
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  bus
);

  localparam int SW = $clog2(STAGES);

  logic [STAGES-1:1]         r_sb_vld;
  logic [STAGES-1:1]         r_sb_we;
  logic [STAGES-1:1]         r_sb_ld;
  logic [STAGES-1:1][RW-1:0] r_sb_rd;
  logic [SW-1:0]             r_fwd_a_p1;
  logic [SW-1:0]             r_fwd_b_p1;
  logic [CNT_W-1:0]          r_stall_cnt;

  logic          w_hit_a;
  logic          w_hit_b;
  logic          w_haz_a;
  logic          w_haz_b;
  logic [SW-1:0] w_k_a;
  logic [SW-1:0] w_k_b;
  logic          w_stall;
  logic          w_issue;

  hazard_match #(
    .STAGES(STAGES), .RW(RW), .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT), .SW(SW)
  ) u_match_a (
    .i_vld(r_sb_vld), .i_we(r_sb_we), .i_ld(r_sb_ld), .i_rd(r_sb_rd),
    .i_rs(bus.dec_rs1), .i_used(bus.dec_rs1_used),
    .o_hit(w_hit_a), .o_k(w_k_a), .o_hazard(w_haz_a)
  );

  hazard_match #(
    .STAGES(STAGES), .RW(RW), .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT), .SW(SW)
  ) u_match_b (
    .i_vld(r_sb_vld), .i_we(r_sb_we), .i_ld(r_sb_ld), .i_rd(r_sb_rd),
    .i_rs(bus.dec_rs2), .i_used(bus.dec_rs2_used),
    .o_hit(w_hit_b), .o_k(w_k_b), .o_hazard(w_haz_b)
  );

  // A redirect squashes decode outright, so it also masks any hazard.
  assign w_stall = bus.dec_valid && !bus.flush && (w_haz_a || w_haz_b);
  assign w_issue = bus.dec_valid && !bus.flush && !w_stall;

  // Decode -> slot 1 / X boundary: control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb_vld    <= '0;
      r_fwd_a_p1  <= SW'(FWD_RF);
      r_fwd_b_p1  <= SW'(FWD_RF);
      r_stall_cnt <= '0;
    end else begin
      r_sb_vld   <= {r_sb_vld[STAGES-2:1], w_issue};
      r_fwd_a_p1 <= (w_issue && w_hit_a) ? w_k_a : SW'(FWD_RF);
      r_fwd_b_p1 <= (w_issue && w_hit_b) ? w_k_b : SW'(FWD_RF);
      if (bus.cnt_clr)
        r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Decode -> slot 1 boundary: entry payload, qualified by r_sb_vld.
  always_ff @(posedge clk) begin
    r_sb_rd <= {r_sb_rd[STAGES-2:1], bus.dec_rd};
    r_sb_we <= {r_sb_we[STAGES-2:1], bus.dec_we};
    r_sb_ld <= {r_sb_ld[STAGES-2:1], bus.dec_is_load};
  end

  assign bus.stall     = w_stall;
  assign bus.issue     = w_issue;
  assign bus.fwd_a_x   = r_fwd_a_p1;
  assign bus.fwd_b_x   = r_fwd_b_p1;
  assign bus.wb_we     = r_sb_vld[STAGES-1] && r_sb_we[STAGES-1] && (r_sb_rd[STAGES-1] != '0);
  assign bus.wb_rd     = r_sb_rd[STAGES-1];
  assign bus.stall_cnt = r_stall_cnt;

endmodule
